// File: rtl/key_press_classifier.sv
// Classifies a debounced push-button into short, double and long presses,
// with auto-repeat pulses while a long press is held. All outputs are registered.
module key_press_classifier #(
   parameter int LONG_CYC   = 50_000_000,
   parameter int DOUBLE_CYC = 15_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int CNT_W      = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic key_level,
   output logic short_tick,
   output logic double_tick,
   output logic long_tick,
   output logic repeat_tick,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS1   = 3'd1,
      WAIT2    = 3'd2,
      WAIT_REL = 3'd3,
      LONG     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TMR_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] TMR_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

   state_t           state_q;
   logic [CNT_W-1:0] timer_q;
   logic             level_q;
   logic             short_q;
   logic             double_q;
   logic             long_q;
   logic             repeat_q;
   logic             busy_q;
   logic             rise_s;

   assign rise_s      = key_level & ~level_q;
   assign short_tick  = short_q;
   assign double_tick = double_q;
   assign long_tick   = long_q;
   assign repeat_tick = repeat_q;
   assign busy        = busy_q;

   // Gesture FSM; pulses default low so each event lasts exactly one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= TMR_ZERO;
         level_q  <= 1'b0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         level_q  <= key_level;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
            timer_q <= TMR_ZERO;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise_s) begin
                     state_q <= PRESS1;
                     timer_q <= TMR_ONE;
                     busy_q  <= 1'b1;
                  end else begin
                     timer_q <= TMR_ZERO;
                     busy_q  <= 1'b0;
                  end
               end
               PRESS1: begin
                  busy_q <= 1'b1;
                  if (!key_level) begin
                     state_q <= WAIT2;
                     timer_q <= TMR_ONE;
                  end else if (timer_q == LONG_LAST) begin
                     state_q <= LONG;
                     timer_q <= TMR_ZERO;
                     long_q  <= 1'b1;
                  end else begin
                     timer_q <= timer_q + TMR_ONE;
                  end
               end
               WAIT2: begin
                  // A press on the timeout cycle counts as double, not short
                  if (key_level) begin
                     state_q  <= WAIT_REL;
                     timer_q  <= TMR_ZERO;
                     double_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end else if (timer_q == DOUBLE_LAST) begin
                     state_q <= IDLE;
                     timer_q <= TMR_ZERO;
                     short_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     timer_q <= timer_q + TMR_ONE;
                     busy_q  <= 1'b1;
                  end
               end
               WAIT_REL: begin
                  timer_q <= TMR_ZERO;
                  if (!key_level) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     busy_q  <= 1'b1;
                  end
               end
               LONG: begin
                  if (!key_level) begin
                     state_q <= IDLE;
                     timer_q <= TMR_ZERO;
                     busy_q  <= 1'b0;
                  end else if (timer_q == REPEAT_LAST) begin
                     timer_q  <= TMR_ZERO;
                     repeat_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end else begin
                     timer_q <= timer_q + TMR_ONE;
                     busy_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  timer_q <= TMR_ZERO;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: directed and random key waveforms compared
// cycle by cycle against a gesture-level reference model.
module tb_key_press_classifier;

   localparam int LONG = 20;
   localparam int DBL  = 10;
   localparam int REP  = 5;
   localparam int NMAX = 5000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic key_level = 1'b0;
   logic short_tick, double_tick, long_tick, repeat_tick, busy;

   int vectors = 0;
   int miscompares = 0;

   bit kv [NMAX];
   bit e_s [NMAX+1];
   bit e_d [NMAX+1];
   bit e_l [NMAX+1];
   bit e_r [NMAX+1];
   bit e_b [NMAX+1];
   logic o_s [NMAX+1];
   logic o_d [NMAX+1];
   logic o_l [NMAX+1];
   logic o_r [NMAX+1];
   logic o_b [NMAX+1];
   int n = 0;

   key_press_classifier #(
      .LONG_CYC(LONG), .DOUBLE_CYC(DBL), .REPEAT_CYC(REP), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .key_level(key_level),
      .short_tick(short_tick), .double_tick(double_tick), .long_tick(long_tick),
      .repeat_tick(repeat_tick), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic k, input logic e);
      key_level = k;
      en = e;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input bit k, input int len);
      for (int i = 0; i < len; i++) begin
         kv[n] = k;
         n++;
      end
   endtask

   // Gesture-level model: walk presses by run lengths of high/low and place events
   task automatic build_expected();
      int c, h, f, l, r, h2, res;
      c = 0;
      while (c < n) begin
         if (kv[c] && (c == 0 || !kv[c-1])) begin
            h = 0;
            while (c + h < n && kv[c+h]) h++;
            if (h >= LONG) begin
               e_l[c+LONG] = 1'b1;
               for (int k = 1; LONG + k*REP <= h; k++) e_r[c+LONG+k*REP] = 1'b1;
               res = c + h + 1;
            end else begin
               f = c + h;
               l = 0;
               while (f + l < n && !kv[f+l]) l++;
               if (l >= DBL) begin
                  e_s[f+DBL] = 1'b1;
                  res = f + DBL;
               end else begin
                  r = f + l;
                  h2 = 0;
                  while (r + h2 < n && kv[r+h2]) h2++;
                  e_d[r+1] = 1'b1;
                  res = r + h2 + 1;
               end
            end
            for (int b = c + 1; b < res; b++) if (b <= n) e_b[b] = 1'b1;
            c = res;
         end else begin
            c++;
         end
      end
   endtask

   initial begin
      int b1, b2, b3, b4, b5, s, rel;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_short", short_tick, 1'b0);
      chk("reset_double", double_tick, 1'b0);
      chk("reset_long", long_tick, 1'b0);
      chk("reset_repeat", repeat_tick, 1'b0);
      chk("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 1'b1);

      // Waveform: the five reference gestures, then random gestures
      b1 = n; add(1, 5);  add(0, 40);
      b2 = n; add(1, 3);  add(0, 4); add(1, 3); add(0, 40);
      b3 = n; add(1, 32); add(0, 40);
      b4 = n; add(1, 19); add(0, 40);
      b5 = n; add(1, 3);  add(0, 9); add(1, 4); add(0, 40);
      for (int g = 0; g < 60; g++) begin
         add(1, $urandom_range(34, 1));
         if ($urandom_range(1, 0) == 0) add(0, $urandom_range(12, 1));
         else add(0, $urandom_range(25, 8));
      end
      add(0, 40);
      build_expected();

      for (int t = 0; t < n; t++) begin
         tick(kv[t], 1'b1);
         o_s[t+1] = short_tick;
         o_d[t+1] = double_tick;
         o_l[t+1] = long_tick;
         o_r[t+1] = repeat_tick;
         o_b[t+1] = busy;
         chk($sformatf("short@%0d", t+1), short_tick, e_s[t+1]);
         chk($sformatf("double@%0d", t+1), double_tick, e_d[t+1]);
         chk($sformatf("long@%0d", t+1), long_tick, e_l[t+1]);
         chk($sformatf("repeat@%0d", t+1), repeat_tick, e_r[t+1]);
         chk($sformatf("busy@%0d", t+1), busy, e_b[t+1]);
      end

      // Reference gesture timing checked directly against the recorded DUT outputs
      chk("sc1_short15", o_s[b1+15], 1'b1);
      chk("sc1_busy15", o_b[b1+15], 1'b0);
      chk("sc2_double8", o_d[b2+8], 1'b1);
      chk("sc3_long20", o_l[b3+20], 1'b1);
      chk("sc3_rep25", o_r[b3+25], 1'b1);
      chk("sc3_rep30", o_r[b3+30], 1'b1);
      chk("sc3_busy33", o_b[b3+33], 1'b0);
      chk("sc4_short29", o_s[b4+29], 1'b1);
      chk("sc5_double13", o_d[b5+13], 1'b1);

      // Asynchronous reset in the middle of a long press
      for (int t = 0; t < 23; t++) tick(1'b1, 1'b1);
      chk("sc6_busy_before_rst", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("sc6_rst_busy", busy, 1'b0);
      chk("sc6_rst_short", short_tick, 1'b0);
      chk("sc6_rst_double", double_tick, 1'b0);
      chk("sc6_rst_long", long_tick, 1'b0);
      chk("sc6_rst_repeat", repeat_tick, 1'b0);
      for (int t = 0; t < 6; t++) begin
         tick(1'b1, 1'b1);
         chk($sformatf("sc6_rst_hold_repeat%0d", t), repeat_tick, 1'b0);
         chk($sformatf("sc6_rst_hold_busy%0d", t), busy, 1'b0);
      end

      // Key held across reset release is a fresh press: short at relative 15
      rst_n = 1'b1;
      for (rel = 0; rel < 30; rel++) begin
         tick(rel < 5, 1'b1);
         s = rel + 1;
         chk($sformatf("relpress_short%0d", s), short_tick, s == 15);
         chk($sformatf("relpress_long%0d", s), long_tick, 1'b0);
         chk($sformatf("relpress_busy%0d", s), busy, (s >= 1 && s <= 14));
      end

      // Enable dropped during cycles 5-8 of a press; held key is then ignored
      for (int t = 0; t < 45; t++) begin
         tick(t <= 12, !(t >= 5 && t <= 8));
         s = t + 1;
         chk($sformatf("en_short%0d", s), short_tick, 1'b0);
         chk($sformatf("en_double%0d", s), double_tick, 1'b0);
         chk($sformatf("en_long%0d", s), long_tick, 1'b0);
         chk($sformatf("en_repeat%0d", s), repeat_tick, 1'b0);
         chk($sformatf("en_busy%0d", s), busy, (s >= 1 && s <= 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
